// File: rtl/alu_operand_stage.sv
// alu_operand_stage
//
// Operand-fetch stage that sits directly in front of the ALU. It holds the
// 32-entry MIPS register file and builds operands A and B plus the opcode Op.
// The stage registers these into one output set that has a valid/ready
// handshake. The stage supports stall, flush and same-cycle write-to-read
// bypass. While a held set is stalled, writeback can refresh its register
// operands.
//
// Ports:
//   clk, rst_n         clock (rising edge) and asynchronous active-low reset
//   in_valid/in_ready  issue handshake from the decoder side
//   rs_addr, rt_addr   source register addresses for A and B
//   imm, sel_imm       16-bit immediate; sel_imm=1 puts the extended imm on B
//   sign_ext           1: sign-extend imm, 0: zero-extend imm
//   op_in              ALU opcode, passed through untouched
//   flush              discards the held operand set (and any same-cycle issue)
//   we, wr_addr, wr_data  register file write port from writeback
//   a, b, op           registered operand set presented to the ALU
//   out_valid/out_ready   handshake toward the ALU

module alu_operand_stage #(
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] rs_addr,
    input  logic [AW-1:0] rt_addr,
    input  logic [15:0]   imm,
    input  logic          sel_imm,
    input  logic          sign_ext,
    input  logic [3:0]    op_in,
    input  logic          flush,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] a,
    output logic [DW-1:0] b,
    output logic [3:0]    op,
    output logic          out_valid,
    input  logic          out_ready
);

    logic [DW-1:0] regs [NREGS];

    logic [DW-1:0] rs_val;
    logic [DW-1:0] rt_val;
    logic [DW-1:0] imm_ext;
    logic [DW-1:0] b_sel;
    logic          wr_live;
    logic          issue;
    logic          transfer;

    logic [AW-1:0] cap_rs;
    logic [AW-1:0] cap_rt;
    logic          cap_sel_imm;

    // A write to register 0 has no effect, so it must never bypass or refresh.
    assign wr_live = we && (wr_addr != '0);

    // Register 0 always reads as zero. Any other address sees a write that
    // lands on the same edge (write-before-read).
    always_comb begin
        rs_val = regs[rs_addr];
        if (rs_addr == '0) begin
            rs_val = '0;
        end else if (wr_live && (wr_addr == rs_addr)) begin
            rs_val = wr_data;
        end
    end

    always_comb begin
        rt_val = regs[rt_addr];
        if (rt_addr == '0) begin
            rt_val = '0;
        end else if (wr_live && (wr_addr == rt_addr)) begin
            rt_val = wr_data;
        end
    end

    // Immediate extension; the upper bits are either copies of imm[15] or zero.
    always_comb begin
        imm_ext = {{(DW-16){sign_ext & imm[15]}}, imm};
        b_sel   = sel_imm ? imm_ext : rt_val;
    end

    assign in_ready = !out_valid || out_ready;
    assign issue    = in_valid && in_ready;
    assign transfer = out_valid && out_ready;

    // Register file. Entry 0 is never written, so it stays zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Output operand set. Flush beats issue. Issue beats a plain transfer.
    // A stalled set tracks writeback to the registers it was built from, so
    // the ALU never consumes a stale value when it finally accepts the set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a           <= '0;
            b           <= '0;
            op          <= 4'b0000;
            out_valid   <= 1'b0;
            cap_rs      <= '0;
            cap_rt      <= '0;
            cap_sel_imm <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (issue) begin
            a           <= rs_val;
            b           <= b_sel;
            op          <= op_in;
            out_valid   <= 1'b1;
            cap_rs      <= rs_addr;
            cap_rt      <= rt_addr;
            cap_sel_imm <= sel_imm;
        end else if (transfer) begin
            out_valid <= 1'b0;
        end else if (out_valid && wr_live) begin
            if (wr_addr == cap_rs) begin
                a <= wr_data;
            end
            if (!cap_sel_imm && (wr_addr == cap_rt)) begin
                b <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage
//
// Self-checking bench for alu_operand_stage. A behavioural model tracks the
// architectural registers and the operand set the ALU should see. Directed
// scenarios come first, followed by a randomized run.

module tb_alu_operand_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [15:0] imm;
    logic        sel_imm;
    logic        sign_ext;
    logic [3:0]  op_in;
    logic        flush;
    logic        we;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        out_valid;
    logic        out_ready;

    int checks_total  = 0;
    int checks_passed = 0;

    // Reference model state: what the architecture says the ALU should see.
    logic [31:0] m_regs [32];
    logic        m_valid;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [3:0]  m_op;
    logic [4:0]  m_rs;
    logic [4:0]  m_rt;
    logic        m_sel;

    alu_operand_stage #(.NREGS(32), .AW(5), .DW(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .imm       (imm),
        .sel_imm   (sel_imm),
        .sign_ext  (sign_ext),
        .op_in     (op_in),
        .flush     (flush),
        .we        (we),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against the value the bench expects.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks_total++;
        if (observed === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_valid = 1'b0;
        m_a = '0; m_b = '0; m_op = '0;
        m_rs = '0; m_rt = '0; m_sel = 1'b0;
    endtask

    // Architectural read as seen this cycle: register 0 is zero, and a write
    // landing on this edge is already visible.
    function automatic logic [31:0] archRead(input logic [4:0] addr);
        if (addr == 5'd0) return 32'd0;
        if (we && wr_addr == addr) return wr_data;
        return m_regs[addr];
    endfunction

    task automatic applyStimulus(input logic iv, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [15:0] im, input logic si, input logic se,
                                 input logic [3:0] opc, input logic fl, input logic w,
                                 input logic [4:0] wa, input logic [31:0] wd,
                                 input logic ordy);
        in_valid = iv; rs_addr = rs; rt_addr = rt; imm = im; sel_imm = si;
        sign_ext = se; op_in = opc; flush = fl; we = w; wr_addr = wa;
        wr_data = wd; out_ready = ordy;
    endtask

    // Run one clock with the current inputs. The task checks in_ready before
    // the edge, advances the model, and checks the registered outputs after.
    task automatic stepCycle();
        logic        exp_ready;
        logic        accept;
        logic        n_valid;
        logic [31:0] n_a, n_b;
        logic [3:0]  n_op;
        logic [4:0]  n_rs, n_rt;
        logic        n_sel;
        logic [31:0] ext;
        #1;
        exp_ready = !m_valid || out_ready;
        checkOutput("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
        accept = in_valid && exp_ready;
        n_valid = m_valid; n_a = m_a; n_b = m_b; n_op = m_op;
        n_rs = m_rs; n_rt = m_rt; n_sel = m_sel;
        ext = sign_ext ? {{16{imm[15]}}, imm} : {16'd0, imm};
        if (flush) begin
            n_valid = 1'b0;
        end else if (accept) begin
            n_valid = 1'b1;
            n_a = archRead(rs_addr);
            n_b = sel_imm ? ext : archRead(rt_addr);
            n_op = op_in; n_rs = rs_addr; n_rt = rt_addr; n_sel = sel_imm;
        end else if (m_valid && out_ready) begin
            n_valid = 1'b0;
        end else if (m_valid && we && wr_addr != 5'd0) begin
            if (wr_addr == m_rs) n_a = wr_data;
            if (!m_sel && wr_addr == m_rt) n_b = wr_data;
        end
        @(posedge clk);
        if (we && wr_addr != 5'd0) m_regs[wr_addr] = wr_data;
        m_valid = n_valid; m_a = n_a; m_b = n_b; m_op = n_op;
        m_rs = n_rs; m_rt = n_rt; m_sel = n_sel;
        #1;
        checkOutput("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        checkOutput("a", a, m_a);
        checkOutput("b", b, m_b);
        checkOutput("op", {28'd0, op}, {28'd0, m_op});
    endtask

    // Stimulus: directed scenarios first, then a randomized run.
    initial begin
        modelReset();
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(posedge clk); @(posedge clk); #1;
        checkOutput("rst_a", a, 32'd0);
        checkOutput("rst_b", b, 32'd0);
        checkOutput("rst_op", {28'd0, op}, 32'd0);
        checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;

        // Basic register operands
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 32'h0000000A, 1); stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 32'h00000001, 1); stepCycle();
        applyStimulus(1, 3, 4, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 1); stepCycle();
        checkOutput("t1_a", a, 32'h0000000A);
        checkOutput("t1_b", b, 32'h00000001);
        checkOutput("t1_valid", {31'd0, out_valid}, 32'd1);

        // Immediate extension and register 0
        applyStimulus(1, 0, 0, 16'hFFFE, 1, 1, 4'b0010, 0, 0, 0, 0, 1); stepCycle();
        checkOutput("t2_sext_b", b, 32'hFFFFFFFE);
        checkOutput("t2_sext_a", a, 32'd0);
        applyStimulus(1, 0, 0, 16'hFFFE, 1, 0, 4'b0010, 0, 0, 0, 0, 1); stepCycle();
        checkOutput("t2_zext_b", b, 32'h0000FFFE);
        checkOutput("t2_zext_a", a, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'd5, 1); stepCycle();
        applyStimulus(1, 0, 0, 0, 0, 0, 4'b0011, 0, 0, 0, 0, 1); stepCycle();
        checkOutput("t2_r0_a", a, 32'd0);
        checkOutput("t2_r0_b", b, 32'd0);

        // Same-cycle bypass
        applyStimulus(1, 7, 0, 0, 1, 0, 4'b1100, 0, 1, 7, 32'hC910C3A5, 1); stepCycle();
        checkOutput("t3_bypass_a", a, 32'hC910C3A5);
        checkOutput("t3_op", {28'd0, op}, 32'd12);

        // Stall refresh
        applyStimulus(1, 5, 6, 0, 0, 0, 4'b0010, 0, 0, 0, 0, 1); stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 32'h12345678, 0); stepCycle();
        checkOutput("t4_refresh_a", a, 32'h12345678);
        checkOutput("t4_valid", {31'd0, out_valid}, 32'd1);
        applyStimulus(1, 1, 1, 0, 0, 0, 4'b0011, 0, 1, 6, 32'h0BADF00D, 0); stepCycle();
        checkOutput("t4_blocked_op", {28'd0, op}, 32'd2);
        checkOutput("t4_refresh_b", b, 32'h0BADF00D);
        checkOutput("t4_in_ready", {31'd0, in_ready}, 32'd0);

        // Back-to-back issue at full throughput
        begin
            logic [3:0] ops [4];
            ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b1000; ops[3] = 4'b1101;
            for (int k = 0; k < 4; k++) begin
                applyStimulus(1, 3, 4, 0, 0, 0, ops[k], 0, 0, 0, 0, 1); stepCycle();
                checkOutput("t5_op", {28'd0, op}, {28'd0, ops[k]});
                checkOutput("t5_valid", {31'd0, out_valid}, 32'd1);
            end
        end

        // Flush with a same-cycle issue
        applyStimulus(1, 3, 4, 0, 0, 0, 4'b0101, 1, 0, 0, 0, 1); stepCycle();
        checkOutput("t6_flush_valid", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset while stalled
        applyStimulus(1, 3, 4, 0, 0, 0, 4'b0111, 0, 0, 0, 0, 1); stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); stepCycle();
        #1 rst_n = 1'b0;
        #1;
        checkOutput("t7_async_a", a, 32'd0);
        checkOutput("t7_async_b", b, 32'd0);
        checkOutput("t7_async_op", {28'd0, op}, 32'd0);
        checkOutput("t7_async_valid", {31'd0, out_valid}, 32'd0);
        modelReset();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Randomized traffic over a small address range to provoke bypass hits
        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 1),
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          4'($urandom), ($urandom_range(0, 9) == 0),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                          $urandom, ($urandom_range(0, 2) != 0));
            stepCycle();
        end

        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Upstream neighbour of the ALU: holds the 32x32 MIPS register file and builds the ALU operands A, B and Op.
- Reads Rs/Rt, selects Rt or an extended 16-bit immediate for B, and registers A/B/Op into one output stage with a valid/ready handshake.
- Supports stall, flush, write-to-read bypass and refresh of held operands while stalled.

Parameters:
- NREGS, 32, number of architectural registers (register 0 hardwired to zero).
- AW, 5, register address width; must satisfy 2**AW = NREGS.
- DW, 32, data width of registers, operands and write data.

Ports:
- Clk  in  1  single clock; all state updates on the rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- In_Valid  in  1  an issue request is present on the input fields.
- In_Ready  out  1  stage can accept an issue this cycle.
- Rs_Addr  in  AW  source register for A.
- Rt_Addr  in  AW  source register for B when Sel_Imm=0.
- Imm  in  16  immediate field.
- Sel_Imm  in  1  1: B = extended Imm; 0: B = R[Rt].
- Sign_Ext  in  1  1: sign-extend Imm; 0: zero-extend Imm.
- Op_In  in  4  ALU opcode, passed through unchanged.
- Flush  in  1  discards the held operand set.
- We  in  1  register write enable (from writeback).
- Wr_Addr  in  AW  write address.
- Wr_Data  in  DW  write data.
- A  out  DW  registered ALU operand A.
- B  out  DW  registered ALU operand B; for shift/rotate ops B carries the shift amount.
- Op  out  4  registered ALU opcode.
- Out_Valid  out  1  A/B/Op hold a valid operand set.
- Out_Ready  in  1  ALU side consumes the operand set this cycle.

Behaviour:
- Reset (async, Rst_n=0):
  - All registers R[0..NREGS-1] = 0.
  - A = 0, B = 0, Op = 4'b0000, Out_Valid = 0.
  - The captured-address and captured-Sel_Imm registers = 0.
  - Reset mid-transfer drops the held set; nothing is replayed after reset.
- Register file write:
  - On a clock edge with We=1 and Wr_Addr != 0, R[Wr_Addr] <= Wr_Data.
  - Writes to address 0 are ignored; reads of 0 always return 0.
- Read bypass: in the same cycle, if We=1, Wr_Addr != 0 and Wr_Addr equals the read address, the read returns Wr_Data (write-before-read).
- Immediate extension:
  - Sign_Ext=1: {{16{Imm[15]}}, Imm}.
  - Sign_Ext=0: {16'b0, Imm}.
- Handshake:
  - In_Ready = !Out_Valid || Out_Ready (combinational).
  - Issue happens when In_Valid && In_Ready. It captures A = bypassed R[Rs], B = bypassed R[Rt] or the extended Imm, Op = Op_In, plus Rs_Addr, Rt_Addr and Sel_Imm.
  - Issue sets Out_Valid=1; latency is 1 cycle from issue to Out_Valid.
  - A transfer occurs when Out_Valid && Out_Ready.
  - Transfer with no issue in the same cycle: Out_Valid <= 0, and A/B/Op hold their last values.
  - Transfer and issue in the same cycle: the new set loads and Out_Valid stays 1, giving full throughput.
- Stall refresh: while Out_Valid=1 and Out_Ready=0, a write with We=1, Wr_Addr != 0 causes:
  - A <= Wr_Data if Wr_Addr equals the captured Rs.
  - B <= Wr_Data if Sel_Imm was 0 and Wr_Addr equals the captured Rt.
  - Both update if both match.
- Flush (synchronous, highest priority after reset):
  - Out_Valid <= 0.
  - Any same-cycle issue is discarded, although In_Ready still reports its normal value.
  - Register file writes still occur during Flush.
- Op and B are not interpreted; all 16 opcode values pass through unchanged.

Test Plan:
- Reset, write R[3]=32'h0000000A and R[4]=32'h00000001, then issue Rs=3, Rt=4, Sel_Imm=0, Op_In=0000 with Out_Ready=1 -> next cycle A=0x0A, B=0x01, Op=0000, Out_Valid=1.
- Issue Rs=0 with Sel_Imm=1, Imm=16'hFFFE: Sign_Ext=1 -> B=0xFFFFFFFE; Sign_Ext=0 -> B=0x0000FFFE; A=0 in both cases. Also write R[0]=5 and read it back -> 0.
- Same-cycle bypass: We=1, Wr_Addr=7, Wr_Data=0xC910C3A5 while issuing Rs=7, Op_In=1100 -> A=0xC910C3A5 on the next cycle.
- Stall: hold Out_Ready=0 with Rs=5 captured, then write R[5]=0x12345678 -> A updates to 0x12345678, Out_Valid stays 1, In_Ready=0 and new issues are blocked.
- Back-to-back: In_Valid=1 and Out_Ready=1 for 4 cycles with Op_In 0000, 0001, 1000, 1101 -> one set per cycle and Out_Valid never drops.
- Flush together with In_Valid=1 -> Out_Valid=0 next cycle. Separately, assert Rst_n=0 mid-stall -> outputs go to 0 immediately without waiting for a clock edge.
